// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and default sizing for the frame-buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    // Default geometry of the frame-buffer RAM and pixel format {R,G,B}.
    localparam int c_DEF_ADDR_WIDTH = 20;
    localparam int c_DEF_DATA_WIDTH = 24;
    localparam int c_DEF_DEPTH      = 20000;
    localparam logic [c_DEF_DATA_WIDTH-1:0] c_DEF_FILL = 24'hFFFFFF;

    // Width of the burst counter; bounds BURST_MAX to 1..15.
    localparam int c_CNT_WIDTH = 4;

    // Which requester currently holds the burst.
    typedef enum logic [0:0] {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/fb_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_rsp_pipe
// Description : LATENCY-deep shift register of {valid, in_range} tags that
//               tracks outstanding RAM reads; synchronous clear drops every
//               in-flight entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rsp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic push_i,
    input  logic in_range_i,
    output logic valid_o,
    output logic in_range_o
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] in_range_q;

    if (LATENCY == 1) begin : g_single
        // One stage: capture the tag of this cycle's read grant.
        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                valid_q    <= '0;
                in_range_q <= '0;
            end else begin
                valid_q    <= push_i;
                in_range_q <= in_range_i;
            end
        end
    end else begin : g_multi
        // Several stages: shift the tag toward the output one stage per cycle.
        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                valid_q    <= '0;
                in_range_q <= '0;
            end else begin
                valid_q    <= {valid_q[LATENCY-2:0], push_i};
                in_range_q <= {in_range_q[LATENCY-2:0], in_range_i};
            end
        end
    end

    assign valid_o    = valid_q[LATENCY-1];
    assign in_range_o = in_range_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Shares one single-port frame-buffer RAM between the capture
//               writer and the display reader. Bounded-burst round robin with
//               a read-urgency override, address range checking and fixed-
//               latency read responses (fill colour for out-of-range reads).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
    parameter int DEPTH        = c_DEF_DEPTH,
    parameter int READ_LATENCY = 1,
    parameter int BURST_MAX    = 4,
    parameter logic [DATA_WIDTH-1:0] FILL = c_DEF_FILL
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  rd_urgent_i,
    output logic                  rd_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rd_rsp_data_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [15:0]           wr_stall_count_o
);

    localparam logic [c_CNT_WIDTH-1:0] c_BURST_MAX = c_CNT_WIDTH'(BURST_MAX);
    // One extra bit so DEPTH itself is representable for the unsigned compare.
    localparam logic [ADDR_WIDTH:0]    c_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [15:0]            c_STALL_MAX = 16'hFFFF;

    owner_e                 owner_q, owner_d;
    logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]            stall_q, stall_d;

    logic   w_grant_rd;
    logic   w_grant_wr;
    owner_e w_grantee;
    logic   w_wr_in_range;
    logic   w_rd_in_range;
    logic   w_pipe_valid;
    logic   w_pipe_in_range;

    assign w_wr_in_range = ({1'b0, wr_addr_i} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr_i} < c_DEPTH);
    assign w_grantee     = w_grant_wr ? OWN_WR : OWN_RD;

    // Grant decision: at most one requester per cycle, nothing while in reset.
    always_comb begin
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        if (!rst_i) begin
            if (rd_valid_i && wr_valid_i) begin
                if (rd_urgent_i) begin
                    w_grant_rd = 1'b1;
                end else if (cnt_q < c_BURST_MAX) begin
                    // Owner keeps the slot until its burst budget runs out.
                    w_grant_rd = (owner_q == OWN_RD);
                    w_grant_wr = (owner_q == OWN_WR);
                end else begin
                    w_grant_rd = (owner_q == OWN_WR);
                    w_grant_wr = (owner_q == OWN_RD);
                end
            end else begin
                w_grant_rd = rd_valid_i;
                w_grant_wr = wr_valid_i;
            end
        end
    end

    // Next-state for owner, burst counter and the saturating stall counter.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        if (!rd_valid_i && !wr_valid_i) begin
            cnt_d = '0;
        end else if (w_grant_rd || w_grant_wr) begin
            if (w_grantee == owner_q) begin
                cnt_d = (cnt_q >= c_BURST_MAX) ? c_BURST_MAX : cnt_q + 1'b1;
            end else begin
                owner_d = w_grantee;
                cnt_d   = c_CNT_WIDTH'(1);
            end
        end
        if (wr_valid_i && !w_grant_wr && (stall_q != c_STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_RD;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // RAM drive straight from the grant; out-of-range accesses keep the slot
    // but never touch the RAM.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = wr_addr_i;
        mem_wdata_o = wr_data_i;
        if (w_grant_wr) begin
            mem_en_o = w_wr_in_range;
            mem_we_o = w_wr_in_range;
        end else if (w_grant_rd) begin
            mem_en_o   = w_rd_in_range;
            mem_addr_o = rd_addr_i;
        end
    end

    fb_rsp_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rsp_pipe (
        .clk_i      (clk_i),
        .clr_i      (rst_i),
        .push_i     (w_grant_rd),
        .in_range_i (w_rd_in_range),
        .valid_o    (w_pipe_valid),
        .in_range_o (w_pipe_in_range)
    );

    assign wr_ready_o       = w_grant_wr;
    assign rd_ready_o       = w_grant_rd;
    assign rd_rsp_valid_o   = w_pipe_valid;
    assign rd_rsp_data_o    = w_pipe_in_range ? mem_rdata_i : FILL;
    assign wr_stall_count_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Self-checking bench for fb_arbiter. Two instances (read
//               latency 1 and 3) share one stimulus; each has its own RAM
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam logic [19:0] c_DEPTH = 20'd20000;
    localparam logic [23:0] c_FILL  = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [19:0] wr_addr;
    logic [23:0] wr_data;
    logic        rd_valid;
    logic [19:0] rd_addr;
    logic        rd_urgent;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Power-on RAM contents (word 5 carries the known test pixel).
    function automatic logic [23:0] init_word(input logic [19:0] a);
        if (a == 20'd5) return 24'h123456;
        return {4'h0, a} ^ 24'h5A0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : 3;

        logic        rd_ready, wr_ready, rsp_valid, mem_en, mem_we;
        logic [19:0] mem_addr;
        logic [23:0] mem_wdata, mem_rdata, rsp_data;
        logic [15:0] stall;

        logic [23:0] ram    [0:19999];
        bit          ram_wr [0:19999];
        logic [23:0] em     [0:19999];
        bit          em_wr  [0:19999];
        logic [23:0] rpipe  [0:L-1];
        logic [23:0] q_data [$];
        int          q_due  [$];
        int          pending = 0;

        fb_arbiter #(
            .READ_LATENCY (L)
        ) u_dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .wr_valid_i       (wr_valid),
            .wr_ready_o       (wr_ready),
            .wr_addr_i        (wr_addr),
            .wr_data_i        (wr_data),
            .rd_valid_i       (rd_valid),
            .rd_ready_o       (rd_ready),
            .rd_addr_i        (rd_addr),
            .rd_urgent_i      (rd_urgent),
            .rd_rsp_valid_o   (rsp_valid),
            .rd_rsp_data_o    (rsp_data),
            .mem_en_o         (mem_en),
            .mem_we_o         (mem_we),
            .mem_addr_o       (mem_addr),
            .mem_wdata_o      (mem_wdata),
            .mem_rdata_i      (mem_rdata),
            .wr_stall_count_o (stall)
        );

        assign mem_rdata = rpipe[L-1];

        // Single-port RAM model with L-cycle read latency.
        always @(posedge clk) begin
            if (mem_en && mem_we && mem_addr < c_DEPTH) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end
            if (mem_en && !mem_we && mem_addr < c_DEPTH)
                rpipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
            else
                rpipe[0] <= 24'hBADBAD;
            for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
        end

        // Scoreboard: expect a response L cycles after each read handshake.
        always @(negedge clk) begin
            if (rsp_valid) begin
                if (q_data.size() == 0) begin
                    check_eq($sformatf("lane%0d unexpected_rsp", g), 32'(rsp_valid), 32'd0);
                end else begin
                    check_eq($sformatf("lane%0d rsp_data", g), 32'(rsp_data), 32'(q_data[0]));
                    check_eq($sformatf("lane%0d rsp_cycle", g), 32'(cyc), 32'(q_due[0]));
                    void'(q_data.pop_front());
                    void'(q_due.pop_front());
                end
            end else if (q_due.size() != 0 && q_due[0] <= cyc) begin
                check_eq($sformatf("lane%0d missing_rsp", g), 32'(rsp_valid), 32'd1);
                void'(q_data.pop_front());
                void'(q_due.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (rd_addr < c_DEPTH)
                    q_data.push_back(em_wr[rd_addr] ? em[rd_addr] : init_word(rd_addr));
                else
                    q_data.push_back(c_FILL);
                q_due.push_back(cyc + L);
            end
            if (wr_valid && wr_ready && wr_addr < c_DEPTH) begin
                em[wr_addr]    <= wr_data;
                em_wr[wr_addr] <= 1'b1;
            end
            if (rst) begin
                q_data.delete();
                q_due.delete();
            end
            pending <= q_data.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Both requesters held, not urgent: grants must follow RRRRWWWW...
    task automatic run_both(input int n, input string tag);
        rd_valid  = 1'b1;
        wr_valid  = 1'b1;
        rd_urgent = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq({tag, "_rd_ready"}, 32'(g_lane[0].rd_ready), 32'((k % 8) < 4));
            check_eq({tag, "_wr_ready"}, 32'(g_lane[0].wr_ready), 32'((k % 8) >= 4));
            tick();
        end
        rd_valid = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rd_urgent = 1'b0;
        wr_valid = 1'b1; rd_valid = 1'b1;
        wr_addr = 20'd11; wr_data = 24'h0000AA; rd_addr = 20'd10;
        tick();
        tick();
        // Requests during reset must not be granted.
        @(negedge clk);
        check_eq("rst_rd_ready", 32'(g_lane[0].rd_ready), 32'd0);
        check_eq("rst_wr_ready", 32'(g_lane[0].wr_ready), 32'd0);
        check_eq("rst_mem_en", 32'(g_lane[0].mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(g_lane[0].mem_we), 32'd0);
        check_eq("rst_rsp_valid", 32'(g_lane[1].rsp_valid), 32'd0);
        check_eq("rst_stall", 32'(g_lane[0].stall), 32'd0);
        rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
        tick();

        // Single read of word 5.
        rd_valid = 1'b1; rd_addr = 20'd5;
        @(negedge clk);
        check_eq("t1_rd_ready", 32'(g_lane[0].rd_ready), 32'd1);
        check_eq("t1_mem_en", 32'(g_lane[0].mem_en), 32'd1);
        check_eq("t1_mem_we", 32'(g_lane[0].mem_we), 32'd0);
        check_eq("t1_mem_addr", 32'(g_lane[0].mem_addr), 32'd5);
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_rsp_valid", 32'(g_lane[0].rsp_valid), 32'd1);
        check_eq("t1_rsp_data", 32'(g_lane[0].rsp_data), 32'h123456);
        tick();
        @(negedge clk);
        check_eq("t1_rsp_after", 32'(g_lane[0].rsp_valid), 32'd0);
        tick();
        tick();

        // Bounded-burst round robin.
        do_reset();
        wr_addr = 20'd11; rd_addr = 20'd10;
        run_both(16, "rr");
        @(negedge clk);
        check_eq("rr_stall", 32'(g_lane[0].stall), 32'd8);
        tick();

        // Urgent reads starve the writer; stall counter saturates.
        do_reset();
        @(negedge clk);
        check_eq("urg_stall_reset", 32'(g_lane[0].stall), 32'd0);
        rd_valid = 1'b1; wr_valid = 1'b1; rd_urgent = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("urg_rd_ready", 32'(g_lane[0].rd_ready), 32'd1);
            check_eq("urg_wr_ready", 32'(g_lane[0].wr_ready), 32'd0);
            tick();
        end
        repeat (65536) tick();
        @(negedge clk);
        check_eq("urg_stall_sat", 32'(g_lane[0].stall), 32'hFFFF);
        repeat (4) tick();
        @(negedge clk);
        check_eq("urg_stall_hold", 32'(g_lane[0].stall), 32'hFFFF);
        rd_valid = 1'b0; wr_valid = 1'b0; rd_urgent = 1'b0;
        tick();
        tick();

        // Address boundary: DEPTH is out of range, DEPTH-1 is in range.
        do_reset();
        wr_valid = 1'b1; wr_addr = 20'd20000; wr_data = 24'h111111;
        @(negedge clk);
        check_eq("oor_wr_ready", 32'(g_lane[0].wr_ready), 32'd1);
        check_eq("oor_wr_mem_en", 32'(g_lane[0].mem_en), 32'd0);
        check_eq("oor_wr_mem_we", 32'(g_lane[0].mem_we), 32'd0);
        tick();
        wr_addr = 20'd19999; wr_data = 24'hABCDEF;
        @(negedge clk);
        check_eq("edge_wr_ready", 32'(g_lane[0].wr_ready), 32'd1);
        check_eq("edge_wr_mem_en", 32'(g_lane[0].mem_en), 32'd1);
        check_eq("edge_wr_mem_we", 32'(g_lane[0].mem_we), 32'd1);
        check_eq("edge_wr_mem_addr", 32'(g_lane[0].mem_addr), 32'd19999);
        check_eq("edge_wr_mem_wdata", 32'(g_lane[0].mem_wdata), 32'hABCDEF);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 20'd19999;
        @(negedge clk);
        check_eq("edge_rd_mem_en", 32'(g_lane[0].mem_en), 32'd1);
        tick();
        rd_addr = 20'd20000;
        @(negedge clk);
        check_eq("oor_rd_ready", 32'(g_lane[0].rd_ready), 32'd1);
        check_eq("oor_rd_mem_en", 32'(g_lane[0].mem_en), 32'd0);
        tick();
        rd_valid = 1'b0;
        repeat (5) tick();

        // Back-to-back reads: lane 1 (latency 3) answers on three adjacent cycles.
        rd_valid = 1'b1; rd_addr = 20'd100;
        tick();
        rd_addr = 20'd101;
        tick();
        rd_addr = 20'd102;
        tick();
        rd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("b2b_rsp_valid", 32'(g_lane[1].rsp_valid), 32'(k < 3));
            tick();
        end

        // Owner returns to read after reset even when the writer held it.
        wr_valid = 1'b1; wr_addr = 20'd300; wr_data = 24'h5A5A5A;
        repeat (6) tick();
        wr_valid = 1'b0;
        do_reset();
        run_both(5, "own");
        tick();

        // Reset with two reads in flight: their responses must never appear.
        rd_valid = 1'b1; rd_addr = 20'd200;
        tick();
        rd_addr = 20'd201;
        tick();
        do_reset();
        run_both(5, "post_rst");
        repeat (8) tick();

        check_eq("lane0_drain", 32'(g_lane[0].pending), 32'd0);
        check_eq("lane1_drain", 32'(g_lane[1].pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
